// File: rtl/axis_pkg.sv
`default_nettype none
// ============================================================================
// Package  : axis_pkg
// Brief    : Shared types and helpers for the AXI-Stream register pipeline.
// Revision : 1.0 - initial release
// ============================================================================
package axis_pkg;

  // Slice flavour: FULL registers both directions (2-entry skid),
  // FWD registers only the forward path (1 entry, ready combinational).
  typedef enum logic [0:0] {
    AXIS_SLICE_FULL = 1'b0,
    AXIS_SLICE_FWD  = 1'b1
  } axis_slice_mode_e;

  // Width of the occupancy counter: enough to represent 0..2*n_stages,
  // never narrower than one bit so the port stays legal at n_stages = 0.
  function automatic int axis_occ_width(input int n_stages);
    int w;
    w = $clog2(2 * n_stages + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage : axis_pkg
`default_nettype wire

// File: rtl/axis_skid_stage.sv
`default_nettype none
// ============================================================================
// Module   : axis_skid_stage
// Brief    : One AXI-Stream register slice over a packed beat vector.
//            FULL mode: main + skid register, upstream ready is a flop.
//            FWD mode : single register, ready passes combinationally.
// Revision : 1.0 - initial release
// ============================================================================
module axis_skid_stage
  import axis_pkg::*;
#(
  parameter int W    = 9,
  parameter int MODE = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_beat,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_beat
);

  if (MODE == int'(AXIS_SLICE_FWD)) begin : g_fwd

    logic         r_valid;
    logic [W-1:0] r_beat;

    // The register can take a new beat when empty or when its current
    // occupant leaves on this same edge.
    assign s_ready = ~r_valid | m_ready;
    assign m_valid = r_valid;
    assign m_beat  = r_beat;

    // Valid flag: reload whenever the slot is being freed or is empty
    always_ff @(posedge clk) begin
      if (rst) begin
        r_valid <= 1'b0;
      end else if (s_ready) begin
        r_valid <= s_valid;
      end
    end

    // Payload: captured only on an upstream handshake, never reset
    always_ff @(posedge clk) begin
      if (s_ready && s_valid) begin
        r_beat <= s_beat;
      end
    end

  end else begin : g_full

    logic         r_main_valid;
    logic [W-1:0] r_main_beat;
    logic         r_skid_valid;
    logic [W-1:0] r_skid_beat;
    logic         w_main_free;
    logic         w_s_fire;

    // Main is free when empty or when its beat is consumed this edge.
    assign w_main_free = ~r_main_valid | m_ready;
    // Upstream ready is purely the inverse of a flop, which is what
    // breaks the backward timing path.
    assign s_ready     = ~r_skid_valid;
    assign w_s_fire    = s_valid & ~r_skid_valid;
    assign m_valid     = r_main_valid;
    assign m_beat      = r_main_beat;

    // Occupancy flags: skid drains into main first; a beat arriving
    // while main is stalled parks in the skid register.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_main_valid <= 1'b0;
        r_skid_valid <= 1'b0;
      end else if (w_main_free) begin
        // With skid full, s_ready is low so s_valid cannot fire here.
        r_main_valid <= r_skid_valid | s_valid;
        r_skid_valid <= 1'b0;
      end else if (w_s_fire) begin
        r_skid_valid <= 1'b1;
      end
    end

    // Payload movement mirrors the flag logic; data regs are not reset
    always_ff @(posedge clk) begin
      if (w_main_free) begin
        if (r_skid_valid) begin
          r_main_beat <= r_skid_beat;
        end else if (s_valid) begin
          r_main_beat <= s_beat;
        end
      end else if (w_s_fire) begin
        r_skid_beat <= s_beat;
      end
    end

  end

endmodule : axis_skid_stage
`default_nettype wire

// File: rtl/axis_skid_pipe.sv
`default_nettype none
// ============================================================================
// Module   : axis_skid_pipe
// Brief    : N_STAGES cascaded AXI-Stream register slices carrying a
//            multi-word beat plus TLAST, with a beat occupancy counter.
//            N_STAGES = 0 degenerates to a pure wire-through.
// Revision : 1.0 - initial release
// ============================================================================
module axis_skid_pipe
  import axis_pkg::*;
#(
  parameter  int WORD_W         = 8,
  parameter  int BUS_W          = 8,
  parameter  int N_STAGES       = 2,
  parameter  int MODE           = 0,
  localparam int WORDS_PER_BEAT = BUS_W / WORD_W,
  localparam int OCC_W          = axis_occ_width(N_STAGES)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  input  logic [WORDS_PER_BEAT-1:0][WORD_W-1:0] s_data,
  input  logic                                  s_last,
  output logic                                  m_valid,
  input  logic                                  m_ready,
  output logic [WORDS_PER_BEAT-1:0][WORD_W-1:0] m_data,
  output logic                                  m_last,
  output logic [OCC_W-1:0]                      occupancy
);

  // A beat travels as {last, data} so each slice handles one vector.
  localparam int c_beat_w = BUS_W + 1;

  if (N_STAGES == 0) begin : g_passthrough

    assign m_valid   = s_valid;
    assign m_data    = s_data;
    assign m_last    = s_last;
    assign s_ready   = m_ready;
    assign occupancy = '0;

  end else begin : g_pipe

    logic                r_valid_unused;
    logic                w_valid [N_STAGES+1];
    logic                w_ready [N_STAGES+1];
    logic [c_beat_w-1:0] w_beat  [N_STAGES+1];
    logic [OCC_W-1:0]    r_occ;
    logic                w_s_fire;
    logic                w_m_fire;

    assign w_valid[0]        = s_valid;
    assign w_beat[0]         = {s_last, s_data};
    assign w_ready[N_STAGES] = m_ready;

    for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_stage
      axis_skid_stage #(
        .W    (c_beat_w),
        .MODE (MODE)
      ) u_stage (
        .clk     (clk),
        .rst     (rst),
        .s_valid (w_valid[gi]),
        .s_ready (w_ready[gi]),
        .s_beat  (w_beat[gi]),
        .m_valid (w_valid[gi+1]),
        .m_ready (w_ready[gi+1]),
        .m_beat  (w_beat[gi+1])
      );
    end

    assign m_valid          = w_valid[N_STAGES];
    assign {m_last, m_data} = w_beat[N_STAGES];

    // Upstream sees ready low for the whole reset cycle; afterwards the
    // first stage is empty so ready rises as soon as rst drops.
    assign s_ready  = w_ready[0] & ~rst;

    assign w_s_fire = s_valid & s_ready;
    assign w_m_fire = m_valid & m_ready;

    // Beat count across all stages, moved only by boundary handshakes;
    // a simultaneous accept and release leaves it unchanged.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_occ <= '0;
      end else if (w_s_fire && !w_m_fire) begin
        r_occ <= r_occ + OCC_W'(1);
      end else if (!w_s_fire && w_m_fire) begin
        r_occ <= r_occ - OCC_W'(1);
      end
    end

    // Tracks whether anything left the pipe last cycle; kept as a debug
    // observation point alongside the occupancy count.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_valid_unused <= 1'b0;
      end else begin
        r_valid_unused <= w_m_fire;
      end
    end

    assign occupancy = r_occ;

  end

endmodule : axis_skid_pipe
`default_nettype wire

// File: tb/tb_axis_skid_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_skid_pipe
// Brief    : Self-checking bench for axis_skid_pipe: FULL (2 stages),
//            FWD (3 stages) and pass-through (0 stages) instances checked
//            against a queue-based model of an order-preserving pipe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_skid_pipe;

  localparam int WW = 8;
  localparam int BW = 16;
  localparam int BT = BW + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          sv [3];
  logic          sl [3];
  logic          mr [3];
  logic [BW-1:0] sd [3];
  logic          mv [3];
  logic          ml [3];
  logic          sr [3];
  logic [BW-1:0] md [3];
  logic [2:0]    occ0;
  logic [2:0]    occ1;
  logic          occ2;

  axis_skid_pipe #(.WORD_W(WW), .BUS_W(BW), .N_STAGES(2), .MODE(0)) dut_full (
    .clk(clk), .rst(rst), .s_valid(sv[0]), .s_ready(sr[0]), .s_data(sd[0]), .s_last(sl[0]),
    .m_valid(mv[0]), .m_ready(mr[0]), .m_data(md[0]), .m_last(ml[0]), .occupancy(occ0));

  axis_skid_pipe #(.WORD_W(WW), .BUS_W(BW), .N_STAGES(3), .MODE(1)) dut_fwd (
    .clk(clk), .rst(rst), .s_valid(sv[1]), .s_ready(sr[1]), .s_data(sd[1]), .s_last(sl[1]),
    .m_valid(mv[1]), .m_ready(mr[1]), .m_data(md[1]), .m_last(ml[1]), .occupancy(occ1));

  axis_skid_pipe #(.WORD_W(WW), .BUS_W(BW), .N_STAGES(0), .MODE(0)) dut_pass (
    .clk(clk), .rst(rst), .s_valid(sv[2]), .s_ready(sr[2]), .s_data(sd[2]), .s_last(sl[2]),
    .m_valid(mv[2]), .m_ready(mr[2]), .m_data(md[2]), .m_last(ml[2]), .occupancy(occ2));

  // Model: per pipe, a FIFO of accepted beats ({last,data}) in arrival order
  logic [BT-1:0] mq    [2][256];
  logic [BT-1:0] rxlog [2][64];
  int            head [2], tail [2], rxcnt [2], pkt_pos [2], bidx [2];
  bit            hold [2];
  logic [BT-1:0] held [2];
  int            first_s_cyc [2], first_mv_cyc [2], last_m_cyc [2];
  bit            arm_s [2], arm_mv [2];
  int            cyc;
  int            n_chk, n_pass;

  int            occ_k;
  logic [BT-1:0] beat_k;
  bit            fs, fm;

  function automatic int cap(input int k);
    return (k == 0) ? 4 : 3;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Compare process: on every cycle outside reset, check outputs against the model
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      occ_k  = (k == 0) ? int'(occ0) : int'(occ1);
      beat_k = {ml[k], md[k]};
      if (rst) begin
        head[k]    = tail[k];
        hold[k]    = 1'b0;
        pkt_pos[k] = 0;
      end else begin
        fs = (sv[k] & sr[k]) === 1'b1;
        fm = (mv[k] & mr[k]) === 1'b1;
        chk("occupancy", occ_k, tail[k] - head[k]);
        if (hold[k]) begin
          chk("m_valid_hold", mv[k], 1);
          chk("m_beat_hold", beat_k, held[k]);
        end
        if (mv[k] === 1'b1) begin
          chk("m_valid_nonempty", (tail[k] - head[k]) > 0, 1);
          if (tail[k] > head[k]) chk("m_beat_order", beat_k, mq[k][head[k] % 256]);
          if (arm_mv[k]) begin first_mv_cyc[k] = cyc; arm_mv[k] = 1'b0; end
        end
        if ((tail[k] - head[k]) == cap(k) && (k == 0 || mr[k] == 1'b0))
          chk("s_ready_when_full", sr[k], 0);
        if (fs) begin
          mq[k][tail[k] % 256] = {sl[k], sd[k]};
          tail[k]++;
          if (arm_s[k]) begin first_s_cyc[k] = cyc; arm_s[k] = 1'b0; end
        end
        if (fm) begin
          chk("m_last_every_10th", ml[k], (pkt_pos[k] % 10) == 9);
          rxlog[k][rxcnt[k] % 64] = beat_k;
          rxcnt[k]++;
          pkt_pos[k]++;
          last_m_cyc[k] = cyc;
          if (tail[k] > head[k]) head[k]++;
        end
        hold[k] = (mv[k] & ~mr[k]) === 1'b1;
        held[k] = beat_k;
      end
    end
  end

  // Legal AXIS source (holds beat until accepted) plus random sink
  task automatic traffic(input int k, input int nbeats, input int pv, input int pr, input int budget);
    int sent;
    int target;
    int n;
    bit acc;
    sent   = 0;
    n      = 0;
    target = rxcnt[k] + nbeats;
    tick();
    sv[k] = 1'b0;
    while (rxcnt[k] < target && n < budget) begin
      if (!sv[k] && sent < nbeats && $urandom_range(99) < pv) begin
        sv[k] = 1'b1;
        sd[k] = BW'($urandom);
        sl[k] = (bidx[k] % 10) == 9;
      end
      mr[k] = $urandom_range(99) < pr;
      @(negedge clk);
      acc = (sv[k] & sr[k]) === 1'b1;
      tick();
      n++;
      if (acc) begin sent++; bidx[k]++; sv[k] = 1'b0; end
    end
    sv[k] = 1'b0;
    mr[k] = 1'b0;
    chk("traffic_complete", rxcnt[k] - (target - nbeats), nbeats);
  endtask

  // Directed pushes with a fixed data pattern, m_ready held at a given level
  task automatic push(input int k, input int ncyc, input int stop_at, inout int idx);
    bit acc;
    for (int c = 0; c < ncyc; c++) begin
      if (idx < stop_at) begin
        sv[k] = 1'b1;
        sd[k] = BW'(idx + 1);
        sl[k] = (bidx[k] % 10) == 9;
      end else begin
        sv[k] = 1'b0;
      end
      @(negedge clk);
      acc = (sv[k] & sr[k]) === 1'b1;
      tick();
      if (acc) begin idx++; bidx[k]++; end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int idx;
    int base;
    int n;
    bit acc;
    n_chk = 0;
    n_pass = 0;
    cyc = 0;
    for (int k = 0; k < 3; k++) begin
      sv[k] = 1'b0; sl[k] = 1'b0; mr[k] = 1'b0; sd[k] = '0;
    end
    for (int k = 0; k < 2; k++) begin
      head[k] = 0; tail[k] = 0; rxcnt[k] = 0; pkt_pos[k] = 0; bidx[k] = 0;
      hold[k] = 1'b0; arm_s[k] = 1'b0; arm_mv[k] = 1'b0;
    end

    // Reset: s_ready low during reset, empty pipe afterwards
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("s_ready_in_reset_full", sr[0], 0);
    chk("s_ready_in_reset_fwd", sr[1], 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_m_valid_full", mv[0], 0);
    chk("reset_m_valid_fwd", mv[1], 0);
    chk("reset_occ_full", occ0, 0);
    chk("reset_occ_fwd", occ1, 0);
    chk("reset_s_ready_full", sr[0], 1);
    chk("reset_s_ready_fwd", sr[1], 1);

    // 1: full rate streaming, 100 packets, latency and throughput
    arm_s[0] = 1'b1;
    arm_mv[0] = 1'b1;
    traffic(0, 1000, 100, 100, 3000);
    chk("latency_full", first_mv_cyc[0] - first_s_cyc[0], 2);
    chk("throughput_span", last_m_cyc[0] - first_s_cyc[0], 1001);

    // 2: FULL saturates at 4 beats, then drains 01..06 in order
    base = rxcnt[0];
    idx = 0;
    mr[0] = 1'b0;
    push(0, 10, 6, idx);
    @(negedge clk);
    chk("full_accepted", idx, 4);
    chk("full_s_ready_low", sr[0], 0);
    chk("full_occ", occ0, 4);
    tick();
    mr[0] = 1'b1;
    push(0, 20, 6, idx);
    chk("full_drained", rxcnt[0] - base, 6);
    for (int i = 0; i < 6; i++) chk("full_order", rxlog[0][(base + i) % 64][BW-1:0], i + 1);
    mr[0] = 1'b0;

    // 3: FWD saturates at 3; simultaneous in/out keeps occupancy at 3
    base = rxcnt[1];
    idx = 0;
    mr[1] = 1'b0;
    push(1, 6, 4, idx);
    sv[1] = 1'b1;
    sd[1] = BW'(idx + 1);
    sl[1] = (bidx[1] % 10) == 9;
    @(negedge clk);
    chk("fwd_accepted", idx, 3);
    chk("fwd_occ_sat", occ1, 3);
    chk("fwd_s_ready_low", sr[1], 0);
    tick();
    mr[1] = 1'b1;
    @(negedge clk);
    chk("fwd_ready_through", sr[1], 1);
    acc = (sv[1] & sr[1]) === 1'b1;
    tick();
    if (acc) begin bidx[1]++; idx++; end
    sv[1] = 1'b0;
    @(negedge clk);
    chk("fwd_occ_steady", occ1, 3);
    n = 0;
    while (rxcnt[1] < base + 4 && n < 20) begin tick(); n++; end
    chk("fwd_drained", rxcnt[1] - base, 4);
    tick();
    mr[1] = 1'b0;

    // 4: random valid/ready, 100 packets through each pipe
    traffic(0, 1000, 50, 10, 30000);
    traffic(1, 1000, 60, 30, 10000);

    // 5: reset mid-packet with 3 beats held, then a fresh packet
    idx = 0;
    mr[0] = 1'b0;
    push(0, 6, 3, idx);
    @(negedge clk);
    chk("pre_reset_occ", occ0, 3);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_s_ready", sr[0], 0);
    tick();
    rst = 1'b0;
    bidx[0] = 0;
    bidx[1] = 0;
    @(negedge clk);
    chk("post_reset_m_valid", mv[0], 0);
    chk("post_reset_occ", occ0, 0);
    chk("post_reset_s_ready", sr[0], 1);
    base = rxcnt[0];
    traffic(0, 10, 100, 100, 200);
    chk("post_reset_last", rxlog[0][(base + 9) % 64][BW], 1);

    // 6: zero stages is a pure wire-through
    for (int i = 0; i < 8; i++) begin
      sv[2] = 1'($urandom);
      sl[2] = 1'($urandom);
      mr[2] = 1'($urandom);
      sd[2] = BW'($urandom);
      #1;
      chk("pass_m_data", md[2], sd[2]);
      chk("pass_m_valid", mv[2], sv[2]);
      chk("pass_m_last", ml[2], sl[2]);
      chk("pass_s_ready", sr[2], mr[2]);
      chk("pass_occ", occ2, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_axis_skid_pipe
`default_nettype wire
